// File: rtl/manchester_frame_tx_pkg.sv
// Shared definitions for the Manchester frame transmitter: FSM encoding,
// status bit positions and the default start-frame delimiter.
package manchester_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  localparam int STAT_OVERRUN   = 0;
  localparam int STAT_BAD_STATE = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_EMPTY     = 4;

  localparam logic [7:0] SFD_DEFAULT = 8'hD5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/manchester_tx_fifo.sv
// Synchronous FIFO holding {last, data} words for the frame transmitter.
// Writes when full and reads when empty are ignored; both may occur together.
module manchester_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) assert (!(i_rd && o_empty));
  end

endmodule

// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: buffers host words in a FIFO and sends each
// committed frame as preamble, SFD, LSB-first payload and an idle gap.
module manchester_frame_tx
  import manchester_frame_tx_pkg::*;
#(
  parameter int         DATA_W           = 8,
  parameter int         FIFO_DEPTH       = 16,
  parameter int         PREAMBLE_BITS    = 64,
  parameter logic [7:0] SFD              = SFD_DEFAULT,
  parameter int         GAP_BITS         = 12,
  parameter int         CLKS_PER_HALFBIT = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_data_we,
  input  logic                          i_data_last,
  input  logic                          i_status_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_data_count,
  output logic [$clog2(FIFO_DEPTH):0]   o_frames_count,
  output logic [7:0]                    o_status,
  output logic                          o_tx,
  output logic                          o_tx_en
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W    = $clog2(CLKS_PER_HALFBIT + 1);
  localparam int MAX_BITS = max_int(max_int(PREAMBLE_BITS, GAP_BITS), max_int(DATA_W, 8));
  localparam int BIT_W    = $clog2(MAX_BITS) + 1;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic               r_half;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0]  r_shift;
  logic               r_last;
  logic               r_tx;
  logic               r_tx_en;
  logic [CNT_W-1:0]   r_frames;
  logic               r_overrun;
  logic               r_bad_state;

  logic [DATA_W:0]    w_fifo_head;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_half_end;
  logic               w_bit_end;
  logic               w_pop;
  logic               w_start;
  logic               w_accept_last;
  logic               w_overrun_set;
  logic               w_cur_bit;
  logic               w_illegal;
  logic [DATA_W-1:0]  w_shift_nxt;

  manchester_tx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (i_data_we),
    .i_wdata ({i_data_last, i_data}),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_half_end    = (r_state != ST_IDLE) && (r_div == DIV_W'(CLKS_PER_HALFBIT - 1));
  assign w_bit_end     = w_half_end && r_half;
  assign w_pop         = w_bit_end &&
                         (((r_state == ST_SFD) && (r_bit_cnt == BIT_W'(7))) ||
                          ((r_state == ST_DATA) && (r_bit_cnt == BIT_W'(DATA_W - 1)) && !r_last));
  assign w_start       = (r_state == ST_IDLE) && (r_frames != '0);
  assign w_accept_last = i_data_we & i_data_last & ~w_fifo_full;
  assign w_overrun_set = i_data_we & w_fifo_full;
  assign w_shift_nxt   = r_shift >> 1;

  // Value of the bit currently on the wire; the gap and idle carry zero.
  always_comb begin
    w_cur_bit = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      ST_PREAMBLE:     w_cur_bit = ~r_bit_cnt[0];
      ST_SFD:          w_cur_bit = SFD[r_bit_cnt[2:0]];
      ST_DATA:         w_cur_bit = r_shift[0];
      ST_IDLE, ST_GAP: w_cur_bit = 1'b0;
      default:         w_illegal = 1'b1;
    endcase
  end

  // r_tx always holds the half-bit about to be driven: ~b at bit start, b at mid-bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_half    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_last    <= 1'b0;
      r_tx      <= 1'b0;
      r_tx_en   <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) r_div <= w_half_end ? '0 : r_div + 1'b1;
      if (w_half_end) r_half <= ~r_half;
      if (w_half_end && !r_half) r_tx <= w_cur_bit;
      case (r_state)
        ST_IDLE: begin
          r_tx    <= 1'b0;
          r_tx_en <= 1'b0;
          if (w_start) begin
            r_state   <= ST_PREAMBLE;
            r_div     <= '0;
            r_half    <= 1'b0;
            r_bit_cnt <= '0;
            r_tx_en   <= 1'b1;
          end
        end
        ST_PREAMBLE: if (w_bit_end) begin
          if (r_bit_cnt == BIT_W'(PREAMBLE_BITS - 1)) begin
            r_state   <= ST_SFD;
            r_bit_cnt <= '0;
            r_tx      <= ~SFD[0];
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_tx      <= ~r_bit_cnt[0];
          end
        end
        ST_SFD: if (w_bit_end) begin
          if (r_bit_cnt == BIT_W'(7)) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_shift   <= w_fifo_head[DATA_W-1:0];
            r_last    <= w_fifo_head[DATA_W];
            r_tx      <= ~w_fifo_head[0];
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_tx      <= ~SFD[r_bit_cnt[2:0] + 3'd1];
          end
        end
        ST_DATA: if (w_bit_end) begin
          if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
            r_bit_cnt <= '0;
            if (r_last) begin
              r_state <= ST_GAP;
              r_tx    <= 1'b0;
              r_tx_en <= 1'b0;
            end else begin
              r_shift <= w_fifo_head[DATA_W-1:0];
              r_last  <= w_fifo_head[DATA_W];
              r_tx    <= ~w_fifo_head[0];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_shift   <= w_shift_nxt;
            r_tx      <= ~w_shift_nxt[0];
          end
        end
        ST_GAP: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            if (r_bit_cnt == BIT_W'(GAP_BITS - 1)) begin
              r_state   <= ST_IDLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_div     <= '0;
          r_half    <= 1'b0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b0;
          r_tx_en   <= 1'b0;
        end
      endcase
    end
  end

  // A commit and a frame start in the same cycle cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frames <= '0;
    end else if (w_accept_last && !w_start) begin
      r_frames <= r_frames + 1'b1;
    end else if (!w_accept_last && w_start) begin
      r_frames <= r_frames - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun   <= 1'b0;
      r_bad_state <= 1'b0;
    end else begin
      if (w_overrun_set)     r_overrun <= 1'b1;
      else if (i_status_clr) r_overrun <= 1'b0;
      if (w_illegal)         r_bad_state <= 1'b1;
      else if (i_status_clr) r_bad_state <= 1'b0;
    end
  end

  always_comb begin
    o_status                 = '0;
    o_status[STAT_OVERRUN]   = r_overrun;
    o_status[STAT_BAD_STATE] = r_bad_state;
    o_status[STAT_BUSY]      = (r_state != ST_IDLE);
    o_status[STAT_FULL]      = w_fifo_full;
    o_status[STAT_EMPTY]     = w_fifo_empty;
  end

  assign o_data_count   = w_fifo_count;
  assign o_frames_count = r_frames;
  assign o_tx           = r_tx;
  assign o_tx_en        = r_tx_en;

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Directed bench for manchester_frame_tx: frame streams, bit encoding,
// back-to-back spacing, overrun, simultaneous events, reset and illegal state.
module tb_manchester_frame_tx;
  import manchester_frame_tx_pkg::*;

  logic       clk;
  logic       i_rst_n;
  logic [7:0] i_data;
  logic       i_data_we;
  logic       i_data_last;
  logic       i_status_clr;
  logic [4:0] o_data_count;
  logic [4:0] o_frames_count;
  logic [7:0] o_status;
  logic       o_tx;
  logic       o_tx_en;

  int n_assert = 0;
  int n_fail   = 0;

  manchester_frame_tx #(
    .DATA_W           (8),
    .FIFO_DEPTH       (16),
    .PREAMBLE_BITS    (64),
    .SFD              (8'hD5),
    .GAP_BITS         (12),
    .CLKS_PER_HALFBIT (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_data         (i_data),
    .i_data_we      (i_data_we),
    .i_data_last    (i_data_last),
    .i_status_clr   (i_status_clr),
    .o_data_count   (o_data_count),
    .o_frames_count (o_frames_count),
    .o_status       (o_status),
    .o_tx           (o_tx),
    .o_tx_en        (o_tx_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [7:0] d, input logic last);
    i_data      = d;
    i_data_we   = 1'b1;
    i_data_last = last;
    @(negedge clk);
    i_data_we   = 1'b0;
    i_data_last = 1'b0;
  endtask

  // Samples one bit time (8 cycles) starting at the current negedge.
  // Bit 1 reads low 4 then high 4 (9'h1F0 incl. enable), bit 0 the inverse.
  task automatic expect_bit(input string tag, input logic b, input logic wr_end,
                            input logic [7:0] wdata);
    logic [8:0] obs;
    obs    = '0;
    obs[8] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      obs[k] = o_tx;
      if (!o_tx_en) obs[8] = 1'b0;
      if (wr_end && k == 7) begin
        check("count_before_pop", o_data_count, 1);
        i_data      = wdata;
        i_data_we   = 1'b1;
        i_data_last = 1'b0;
      end
      @(negedge clk);
      if (wr_end && k == 7) i_data_we = 1'b0;
    end
    check(tag, obs, b ? 9'h1F0 : 9'h10F);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] v, input logic wr_end,
                             input logic [7:0] wdata);
    for (int i = 0; i < 8; i++) expect_bit(tag, v[i], wr_end && (i == 7), wdata);
  endtask

  task automatic expect_header();
    logic [7:0] sfd_v;
    sfd_v = 8'hD5;
    for (int i = 0; i < 64; i++) expect_bit("preamble", (i % 2) == 0, 1'b0, 8'h00);
    expect_byte("sfd", sfd_v, 1'b0, 8'h00);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_data       = '0;
    i_data_we    = 1'b0;
    i_data_last  = 1'b0;
    i_status_clr = 1'b0;
    wait_clk(3);

    // T1 reset values, then a three-word frame
    check("rst_data_count", o_data_count, 0);
    check("rst_frames", o_frames_count, 0);
    check("rst_status", o_status, 8'h10);
    check("rst_tx", o_tx, 0);
    check("rst_tx_en", o_tx_en, 0);
    i_rst_n = 1'b1;
    @(negedge clk);
    write_word(8'hA5, 1'b0);
    write_word(8'h3C, 1'b0);
    write_word(8'hFF, 1'b1);
    check("t1_frames_commit", o_frames_count, 1);
    check("t1_count", o_data_count, 3);
    check("t1_tx_en_idle", o_tx_en, 0);
    @(negedge clk);
    check("t1_frames_start", o_frames_count, 0);
    check("t1_tx_en_start", o_tx_en, 1);
    expect_header();
    expect_byte("t1_a5", 8'hA5, 1'b0, 8'h00);
    expect_byte("t1_3c", 8'h3C, 1'b0, 8'h00);
    expect_byte("t1_ff", 8'hFF, 1'b0, 8'h00);
    check("t1_gap_tx_en", o_tx_en, 0);
    check("t1_gap_tx", o_tx, 0);
    check("t1_gap_status", o_status, 8'h14);

    // T3 two frames committed during the gap, started back-to-back
    write_word(8'h81, 1'b1);
    write_word(8'h12, 1'b0);
    write_word(8'h34, 1'b1);
    check("t3_frames_2", o_frames_count, 2);
    check("t3_count_3", o_data_count, 3);
    wait_clk(92);
    check("t3_gap_busy_end", o_status, 8'h04);
    wait_clk(1);
    check("t3_idle_status", o_status, 8'h00);
    check("t3_idle_frames", o_frames_count, 2);
    wait_clk(1);
    check("t3_start_a_tx_en", o_tx_en, 1);
    check("t3_frames_1", o_frames_count, 1);
    expect_header();
    expect_byte("t3_81", 8'h81, 1'b0, 8'h00);
    check("t3_a_end_tx_en", o_tx_en, 0);
    check("t3_a_end_count", o_data_count, 2);
    wait_clk(96);
    check("t3_gap96_tx_en", o_tx_en, 0);
    check("t3_gap96_frames", o_frames_count, 1);
    wait_clk(1);
    check("t3_start_b_tx_en", o_tx_en, 1);
    check("t3_frames_0", o_frames_count, 0);
    expect_header();

    // T5 write on the cycle DATA pops the next word
    expect_byte("t3_12", 8'h12, 1'b1, 8'h5A);
    check("t5_count_after_pop", o_data_count, 1);
    expect_byte("t3_34", 8'h34, 1'b0, 8'h00);
    check("t3_b_end_tx_en", o_tx_en, 0);
    write_word(8'h66, 1'b1);
    check("t5_frames_1", o_frames_count, 1);
    check("t5_count_2", o_data_count, 2);
    wait_clk(95);
    check("t5_idle_status", o_status, 8'h00);
    i_data      = 8'h77;
    i_data_we   = 1'b1;
    i_data_last = 1'b1;
    @(negedge clk);
    i_data_we   = 1'b0;
    i_data_last = 1'b0;
    check("t5_frames_unchanged", o_frames_count, 1);
    check("t5_start_tx_en", o_tx_en, 1);
    check("t5_count_3", o_data_count, 3);

    // T6 asynchronous reset in the middle of DATA
    wait_clk(577);
    check("t6_pre_tx", o_tx, 1);
    check("t6_pre_tx_en", o_tx_en, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t6_async_tx", o_tx, 0);
    check("t6_async_tx_en", o_tx_en, 0);
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_count", o_data_count, 0);
    check("t6_post_frames", o_frames_count, 0);
    check("t6_post_status", o_status, 8'h10);
    wait_clk(20);
    check("t6_no_frame", o_tx_en, 0);

    // T4 overrun: seventeenth write (marked last) is dropped
    for (int i = 0; i < 16; i++) write_word(8'(i + 1), 1'b0);
    check("t4_count_16", o_data_count, 16);
    check("t4_status_full", o_status, 8'h08);
    write_word(8'hEE, 1'b1);
    check("t4_count_still_16", o_data_count, 16);
    check("t4_status_overrun", o_status, 8'h09);
    check("t4_dropped_no_commit", o_frames_count, 0);
    i_status_clr = 1'b1;
    @(negedge clk);
    i_status_clr = 1'b0;
    check("t4_clr", o_status, 8'h08);
    i_data       = 8'h55;
    i_data_we    = 1'b1;
    i_status_clr = 1'b1;
    @(negedge clk);
    i_data_we    = 1'b0;
    i_status_clr = 1'b0;
    check("t4_set_wins", o_status, 8'h09);
    i_status_clr = 1'b1;
    @(negedge clk);
    i_status_clr = 1'b0;
    check("t4_clr2", o_status, 8'h08);

    // T6 illegal state recovery
    force dut.r_state = state_t'(3'd7);
    @(negedge clk);
    release dut.r_state;
    @(negedge clk);
    check("t6_bad_state", o_status, 8'h0A);
    check("t6_bad_tx_en", o_tx_en, 0);
    i_status_clr = 1'b1;
    @(negedge clk);
    i_status_clr = 1'b0;
    check("t6_bad_clr", o_status, 8'h08);

    i_rst_n = 1'b0;
    @(negedge clk);
    check("final_rst_status", o_status, 8'h10);
    check("final_rst_count", o_data_count, 0);
    i_rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
